sar_deserializer: RTL and testbench
===================================

SAR_DESERIALIZER -- requirements
Module: sar_deserializer

Interface
REQ-001 Parameter BIT_ADC, default 8: conversion word width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO depth in words; power of two, at least 2.
REQ-003 CLK  input  1: single clock, same 48 MHz clock that drives the SAR logic.
REQ-004 XRST  input  1: reset, synchronous, active-low.
REQ-005 EN  input  1: capture enable; FIFO drain is unaffected by it.
REQ-006 COMP_CLK  input  1: comparator clock from the SAR logic.
REQ-007 DIGITAL_OUT  input  1: serial 1-bit A/D result from the SAR logic, MSB first.
REQ-008 SDAC  input  BIT_ADC+1: CDAC switch vector from the SAR logic; value 1<<BIT_ADC marks the MSB trial.
REQ-009 DATA_OUT  output  BIT_ADC: FIFO head word.
REQ-010 DATA_VALID  output  1: FIFO not empty.
REQ-011 DATA_READY  input  1: consumer accepts the head word.
REQ-012 LEVEL  output  clog2(FIFO_DEPTH)+1: FIFO occupancy.
REQ-013 OVERFLOW  output  1: sticky flag, word dropped because the FIFO was full.
REQ-014 FRAME_ERR  output  1: one-cycle pulse, MSB marker seen with a partial word pending.

Function
REQ-015 The block SHALL register COMP_CLK once (cc_d). Rise = COMP_CLK & ~cc_d. Fall = ~COMP_CLK & cc_d.
REQ-016 On a rise with EN=1, the block SHALL latch msb_flag = (SDAC == 1<<BIT_ADC).
REQ-017 On a fall with EN=1, the block SHALL sample DIGITAL_OUT as the current trial bit.
REQ-018 Bit handling SHALL be:
- msb_flag=1: start a new word; bit goes to word[BIT_ADC-1]; bit counter = 1.
- msb_flag=0 and counter in 1..BIT_ADC-1: store bit at word[BIT_ADC-1-counter]; increment counter.
- msb_flag=0 and counter=0 (unsynchronised): discard the bit.
REQ-019 When msb_flag=1 arrives while the counter is non-zero, the block SHALL discard the partial word, pulse FRAME_ERR for exactly the fall cycle+1, and start the new word.
REQ-020 On the fall that stores bit BIT_ADC-1 (LSB), the block SHALL push the completed word to the FIFO at that clock edge and clear the counter to 0; DATA_VALID SHALL be high on the following cycle if the FIFO was empty.
REQ-021 The FIFO SHALL be first-in first-out. DATA_OUT SHALL be the head word while DATA_VALID=1. A pop occurs on any cycle with DATA_VALID & DATA_READY.
REQ-022 FIFO boundary behaviour:
- DATA_OUT SHALL hold its value while DATA_VALID=1 and DATA_READY=0.
- Push while full with no pop: the new word is dropped, contents are unchanged, and OVERFLOW is set.
- Push and pop in the same cycle while full: both occur; LEVEL is unchanged; no overflow.
- Push and pop in the same cycle while empty: not possible, since DATA_VALID=0.
- Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 When EN=0, the block SHALL ignore rise and fall events and force the counter and msb_flag to 0. The FIFO and DATA_VALID SHALL continue to operate. A partial word in progress when EN falls SHALL be discarded without FRAME_ERR.
REQ-024 OVERFLOW SHALL clear only on reset.
REQ-025 Steady-state throughput SHALL be one word per BIT_ADC comparator periods (8 x 6 = 48 CLK cycles at defaults) with no bit lost.

Reset
REQ-026 With XRST=0 at a CLK rising edge, the block SHALL set DATA_OUT=0, DATA_VALID=0, LEVEL=0, OVERFLOW=0 and FRAME_ERR=0, clear cc_d, msb_flag, the counter and both FIFO pointers, and discard all stored words.
REQ-027 Reset asserted mid-word SHALL leave no residue. After release, the block SHALL remain unsynchronised until the next MSB marker.

Verification
REQ-028 SAR logic model converting 0xA5 with EN=1 and DATA_READY=1 -> DATA_VALID=1 for one cycle with DATA_OUT=0xA5, one cycle after the LSB fall.
REQ-029 Four back-to-back words 0x00, 0xFF, 0x3C, 0x81 with DATA_READY=0 -> LEVEL=4; a fifth word 0x55 -> OVERFLOW=1; draining yields 0x00, 0xFF, 0x3C, 0x81 in order.
REQ-030 FIFO full with a push and a pop in the same cycle -> LEVEL stays 4, OVERFLOW stays 0, new word becomes the tail.
REQ-031 Inject an MSB marker after 3 bits of a word -> FRAME_ERR pulses 1 cycle, partial discarded, next 8 bits form 0x5A correctly.
REQ-032 EN=1 asserted mid-conversion (bit 4) -> bits ignored until the next MSB marker; first word delivered is the full next conversion.
REQ-033 XRST=0 for 1 cycle after 5 bits of a word with LEVEL=2 -> LEVEL=0, DATA_VALID=0; the following complete word is delivered intact.

Source files
------------

// File: rtl/sar_deserializer.sv
// Collects the serial MSB-first SAR result into parallel words, framed by the
// MSB-trial marker on SDAC, and buffers them in a small output FIFO.
module sar_deserializer #(
  parameter int BIT_ADC    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          XRST,
  input  logic                          EN,
  input  logic                          COMP_CLK,
  input  logic                          DIGITAL_OUT,
  input  logic [BIT_ADC:0]              SDAC,
  output logic [BIT_ADC-1:0]            DATA_OUT,
  output logic                          DATA_VALID,
  input  logic                          DATA_READY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          OVERFLOW,
  output logic                          FRAME_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BIT_ADC) + 1;
  localparam logic [BIT_ADC:0] MSB_MARK = {1'b1, {BIT_ADC{1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(BIT_ADC - 1);
  localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);

  logic                 cc_q, cc_d;
  logic                 msb_flag_q, msb_flag_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_ADC-1:0]   word_q, word_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [BIT_ADC-1:0]   mem_q [FIFO_DEPTH];
  logic [BIT_ADC-1:0]   mem_d [FIFO_DEPTH];
  logic                 rise, fall, push, pop, full, wr_en;

  always_comb begin
    cc_d        = COMP_CLK;
    rise        = COMP_CLK & ~cc_q;
    fall        = ~COMP_CLK & cc_q;
    msb_flag_d  = msb_flag_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (!EN) begin
      msb_flag_d = 1'b0;
      cnt_d      = '0;
    end else begin
      if (rise) msb_flag_d = (SDAC == MSB_MARK);
      if (fall) begin
        if (msb_flag_q) begin
          // a marker while a word is pending means the previous frame was cut short
          frame_err_d          = (cnt_q != '0);
          word_d               = '0;
          word_d[BIT_ADC-1]    = DIGITAL_OUT;
          cnt_d                = CW'(1);
        end else if (cnt_q != '0) begin
          for (int i = 0; i < BIT_ADC; i++) begin
            if (cnt_q == CW'(BIT_ADC - 1 - i)) word_d[i] = DIGITAL_OUT;
          end
          if (cnt_q == LAST_CNT) begin
            push  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    pop        = DATA_VALID & DATA_READY;
    full       = (level_q == FULL_LVL);
    wr_en      = push & (~full | pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (wr_en) begin
      mem_d[wr_ptr_q] = word_d;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!XRST) begin
      cc_q        <= 1'b0;
      msb_flag_q  <= 1'b0;
      cnt_q       <= '0;
      word_q      <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cc_q        <= cc_d;
      msb_flag_q  <= msb_flag_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mem_q       <= mem_d;
    end
  end

  assign DATA_VALID = (level_q != '0);
  assign DATA_OUT   = DATA_VALID ? mem_q[rd_ptr_q] : '0;
  assign LEVEL      = level_q;
  assign OVERFLOW   = overflow_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_sar_deserializer.sv
// Directed bench: a SAR sequencer model drives conversions, expected words go
// into a queue and a negedge monitor checks every accepted FIFO word.
module tb_sar_deserializer;

  logic       CLK = 1'b0;
  logic       XRST, EN, COMP_CLK, DIGITAL_OUT, DATA_READY;
  logic [8:0] SDAC;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID, OVERFLOW, FRAME_ERR;
  logic [2:0] LEVEL;

  int         total = 0;
  int         bad = 0;
  int         fe_cycles = 0;
  int         valid_cycles = 0;
  int         fe0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_word;

  sar_deserializer #(.BIT_ADC(8), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .XRST(XRST), .EN(EN), .COMP_CLK(COMP_CLK),
    .DIGITAL_OUT(DIGITAL_OUT), .SDAC(SDAC), .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY), .LEVEL(LEVEL),
    .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One comparator period per bit: 3 cycles high, 3 cycles low.
  task automatic sar_bits(input logic [7:0] w, input int first, input int n, input bit pop_lsb);
    for (int i = first; i < first + n; i++) begin
      SDAC        = (i == 0) ? 9'h100 : (9'h100 >> i);
      DIGITAL_OUT = w[7-i];
      COMP_CLK    = 1'b1;
      repeat (3) tick();
      COMP_CLK = 1'b0;
      if (pop_lsb && i == 7) DATA_READY = 1'b1;
      tick();
      if (pop_lsb && i == 7) DATA_READY = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic convert(input logic [7:0] w, input bit pop_lsb);
    sar_bits(w, 0, 8, pop_lsb);
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    XRST = 1'b0;
    tick();
    exp_q.delete();
    XRST = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (XRST) begin
      if (FRAME_ERR) fe_cycles++;
      if (DATA_VALID) begin
        valid_cycles++;
        if (DATA_READY) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word act=%0h exp=none", DATA_OUT);
          end else begin
            exp_word = exp_q.pop_front();
            chk("data_out", 32'(DATA_OUT), 32'(exp_word));
          end
        end
      end
    end
  end

  initial begin
    XRST = 1'b0; EN = 1'b0; COMP_CLK = 1'b0; DIGITAL_OUT = 1'b0;
    SDAC = '0; DATA_READY = 1'b0;
    repeat (2) tick();
    chk("rst_data_out", 32'(DATA_OUT), 32'd0);
    chk("rst_valid", 32'(DATA_VALID), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_overflow", 32'(OVERFLOW), 32'd0);
    chk("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    XRST = 1'b1;
    EN   = 1'b1;
    tick();

    // single conversion, consumer always ready
    DATA_READY = 1'b1;
    valid_cycles = 0;
    exp_q.push_back(8'hA5);
    convert(8'hA5, 1'b0);
    chk("single_valid_cycles", 32'(valid_cycles), 32'd1);
    chk("single_level", 32'(LEVEL), 32'd0);

    // fill, overflow, drain
    DATA_READY = 1'b0;
    exp_q.push_back(8'h00); convert(8'h00, 1'b0);
    exp_q.push_back(8'hFF); convert(8'hFF, 1'b0);
    exp_q.push_back(8'h3C); convert(8'h3C, 1'b0);
    exp_q.push_back(8'h81); convert(8'h81, 1'b0);
    chk("full_level", 32'(LEVEL), 32'd4);
    chk("full_overflow", 32'(OVERFLOW), 32'd0);
    chk("full_head", 32'(DATA_OUT), 32'h00);
    convert(8'h55, 1'b0);
    chk("ovf_flag", 32'(OVERFLOW), 32'd1);
    chk("ovf_level", 32'(LEVEL), 32'd4);
    chk("ovf_head_hold", 32'(DATA_OUT), 32'h00);
    DATA_READY = 1'b1;
    wait_empty("ovf_drain");
    chk("ovf_drain_level", 32'(LEVEL), 32'd0);
    chk("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // simultaneous push and pop while full
    do_reset();
    DATA_READY = 1'b0;
    exp_q.push_back(8'h11); convert(8'h11, 1'b0);
    exp_q.push_back(8'h22); convert(8'h22, 1'b0);
    exp_q.push_back(8'h33); convert(8'h33, 1'b0);
    exp_q.push_back(8'h44); convert(8'h44, 1'b0);
    exp_q.push_back(8'h66); convert(8'h66, 1'b1);
    chk("pp_level", 32'(LEVEL), 32'd4);
    chk("pp_overflow", 32'(OVERFLOW), 32'd0);
    chk("pp_head", 32'(DATA_OUT), 32'h22);
    DATA_READY = 1'b1;
    wait_empty("pp_drain");

    // marker after three bits of a word
    fe0 = fe_cycles;
    sar_bits(8'hE7, 0, 3, 1'b0);
    chk("fe_none_yet", 32'(fe_cycles - fe0), 32'd0);
    exp_q.push_back(8'h5A);
    convert(8'h5A, 1'b0);
    chk("fe_pulse_cycles", 32'(fe_cycles - fe0), 32'd1);
    wait_empty("fe_word");

    // EN dropped mid-word: partial discarded, no frame error
    fe0 = fe_cycles;
    sar_bits(8'hF0, 0, 3, 1'b0);
    EN = 1'b0;
    tick();
    EN = 1'b1;
    exp_q.push_back(8'h69);
    convert(8'h69, 1'b0);
    chk("en_drop_no_fe", 32'(fe_cycles - fe0), 32'd0);
    wait_empty("en_drop_word");

    // EN raised at bit 4 of a conversion
    EN = 1'b0;
    sar_bits(8'hAA, 0, 4, 1'b0);
    EN = 1'b1;
    sar_bits(8'hAA, 4, 4, 1'b0);
    chk("en_mid_level", 32'(LEVEL), 32'd0);
    exp_q.push_back(8'hC3);
    convert(8'hC3, 1'b0);
    wait_empty("en_mid_word");

    // reset mid-word with two words buffered
    DATA_READY = 1'b0;
    convert(8'h12, 1'b0);
    convert(8'h34, 1'b0);
    chk("mid_rst_pre_level", 32'(LEVEL), 32'd2);
    sar_bits(8'hFF, 0, 5, 1'b0);
    do_reset();
    chk("mid_rst_level", 32'(LEVEL), 32'd0);
    chk("mid_rst_valid", 32'(DATA_VALID), 32'd0);
    sar_bits(8'hFF, 5, 3, 1'b0);
    chk("mid_rst_unsync", 32'(LEVEL), 32'd0);
    DATA_READY = 1'b1;
    exp_q.push_back(8'h96);
    convert(8'h96, 1'b0);
    wait_empty("mid_rst_word");
    chk("final_level", 32'(LEVEL), 32'd0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
